johnson_phase_decoder: RTL

//  Consumes the N-bit state of a Johnson (twisted-ring) counter and decodes it into a phase index and a one-hot phase vector.

---
 rtl/johnson_phase_decoder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/johnson_phase_decoder.sv
// Decodes a Johnson counter state into a phase index and one-hot vector.
// Flags illegal codes and out-of-sequence steps, and tracks lock, errors and rotations.
module johnson_phase_decoder #(
    parameter int unsigned N        = 4,
    parameter int unsigned ERR_W    = 8,
    parameter int unsigned CYC_W    = 16,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clr,
    input  logic [N-1:0]             jc_in,
    output logic                     phase_valid,
    output logic [$clog2(2*N)-1:0]   phase_idx,
    output logic [2*N-1:0]           phase_onehot,
    output logic                     illegal_code,
    output logic                     seq_err,
    output logic                     wrap_pulse,
    output logic                     locked,
    output logic [ERR_W-1:0]         err_count,
    output logic [CYC_W-1:0]         cycle_count
);

    localparam int unsigned P     = 2 * N;
    localparam int unsigned IDX_W = $clog2(P);
    localparam int unsigned RUN_W = 8;

    // Code for phase k: a run of ones filling from bit0, then emptying from bit0.
    function automatic logic [N-1:0] code_of(input int unsigned k);
        logic [N-1:0] c;
        for (int unsigned b = 0; b < N; b++) begin
            c[b] = (k <= N) ? (b < k) : (b >= k - N);
        end
        return c;
    endfunction

    logic [N-1:0]     r_s1_data;
    logic             r_s1_vld;
    logic             r_valid;
    logic [IDX_W-1:0] r_idx;
    logic             r_ill;
    logic             r_seq;
    logic             r_wrap;
    logic             r_locked;
    logic             r_ref;
    logic [RUN_W-1:0] r_run;
    logic [ERR_W-1:0] r_err;
    logic [CYC_W-1:0] r_cyc;

    logic             w_legal;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_step_idx;
    logic             w_valid_d;
    logic [IDX_W-1:0] w_idx_d;
    logic             w_ill_d;
    logic             w_seq_d;
    logic             w_wrap_d;
    logic             w_locked_d;
    logic             w_ref_d;
    logic [RUN_W-1:0] w_run_d;
    logic             w_err_inc;
    logic             w_cyc_inc;
    logic [ERR_W-1:0] w_err_d;
    logic [CYC_W-1:0] w_cyc_d;

    always_comb begin
        w_legal = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 0; k < P; k++) begin
            if (r_s1_data == code_of(k)) begin
                w_legal = 1'b1;
                w_idx   = IDX_W'(k);
            end
        end
    end

    assign w_step_idx = (r_idx == IDX_W'(P - 1)) ? '0 : r_idx + IDX_W'(1);

    always_comb begin
        w_valid_d  = r_valid;
        w_idx_d    = r_idx;
        w_ill_d    = 1'b0;
        w_seq_d    = 1'b0;
        w_wrap_d   = 1'b0;
        w_locked_d = r_locked;
        w_ref_d    = r_ref;
        w_run_d    = r_run;
        w_err_inc  = 1'b0;
        w_cyc_inc  = 1'b0;
        if (r_s1_vld) begin
            if (!w_legal) begin
                w_ill_d    = 1'b1;
                w_valid_d  = 1'b0;
                w_locked_d = 1'b0;
                w_run_d    = '0;
                w_ref_d    = 1'b0;
                w_err_inc  = 1'b1;
            end else begin
                w_valid_d = 1'b1;
                w_idx_d   = w_idx;
                w_ref_d   = 1'b1;
                if (!r_ref) begin
                    w_run_d = '0;
                end else if (w_idx != r_idx) begin
                    if (w_idx == w_step_idx) begin
                        w_run_d    = (r_run == RUN_W'(LOCK_CNT)) ? r_run : r_run + RUN_W'(1);
                        w_locked_d = r_locked | (w_run_d == RUN_W'(LOCK_CNT));
                        if (r_idx == IDX_W'(P - 1)) begin
                            w_wrap_d  = 1'b1;
                            w_cyc_inc = 1'b1;
                        end
                    end else begin
                        w_seq_d    = 1'b1;
                        w_err_inc  = 1'b1;
                        w_locked_d = 1'b0;
                        w_run_d    = '0;
                    end
                end
            end
        end
        w_err_d = (w_err_inc && (r_err != '1)) ? r_err + ERR_W'(1) : r_err;
        w_cyc_d = (w_cyc_inc && (r_cyc != '1)) ? r_cyc + CYC_W'(1) : r_cyc;
        // Clear beats any same-edge event; phase outputs and pulses are left alone.
        if (clr) begin
            w_err_d    = '0;
            w_cyc_d    = '0;
            w_locked_d = 1'b0;
            w_run_d    = '0;
            w_ref_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_data <= '0;
            r_s1_vld  <= 1'b0;
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_ill     <= 1'b0;
            r_seq     <= 1'b0;
            r_wrap    <= 1'b0;
            r_locked  <= 1'b0;
            r_ref     <= 1'b0;
            r_run     <= '0;
            r_err     <= '0;
            r_cyc     <= '0;
        end else begin
            if (en) begin
                r_s1_data <= jc_in;
            end
            r_s1_vld <= en;
            r_valid  <= w_valid_d;
            r_idx    <= w_idx_d;
            r_ill    <= w_ill_d;
            r_seq    <= w_seq_d;
            r_wrap   <= w_wrap_d;
            r_locked <= w_locked_d;
            r_ref    <= w_ref_d;
            r_run    <= w_run_d;
            r_err    <= w_err_d;
            r_cyc    <= w_cyc_d;
        end
    end

    always_comb begin
        phase_onehot = '0;
        if (r_valid) begin
            phase_onehot[r_idx] = 1'b1;
        end
    end

    assign phase_valid  = r_valid;
    assign phase_idx    = r_idx;
    assign illegal_code = r_ill;
    assign seq_err      = r_seq;
    assign wrap_pulse   = r_wrap;
    assign locked       = r_locked;
    assign err_count    = r_err;
    assign cycle_count  = r_cyc;

endmodule
